// File: rtl/hist_pkg.sv
// Shared sizing and state encoding for the histogram accumulator and the
// histogram threshold search block.
package hist_pkg;

    localparam int NUM_BINS = 256;
    localparam int BIN_W    = 16;
    localparam int CUM_W    = 24;
    localparam int IDX_W    = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/histogram_threshold.sv
// Walks a latched histogram one bin per cycle and reports the first bin at
// which the running pixel count reaches the target, plus the total count.
//
// state  | meaning
// S_IDLE | waiting for a histogram; o_hist_ready high
// S_SCAN | accumulating bin[idx] into the running sum, one bin per cycle
// S_DONE | result held on the outputs until downstream takes it
module histogram_threshold #(
    parameter int NUM_BINS = hist_pkg::NUM_BINS,
    parameter int BIN_W    = hist_pkg::BIN_W,
    parameter int CUM_W    = hist_pkg::CUM_W
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_hist_valid,
    input  logic [BIN_W-1:0]         i_histogram [NUM_BINS],
    output logic                     o_hist_ready,
    input  logic [CUM_W-1:0]         i_target,
    output logic [hist_pkg::IDX_W-1:0] o_threshold,
    output logic [CUM_W-1:0]         o_total,
    output logic                     o_found,
    output logic                     o_valid,
    input  logic                     i_ready
);
    import hist_pkg::*;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   thr_q, thr_d;
    logic [CUM_W-1:0]   sum_q, sum_d;
    logic [CUM_W-1:0]   target_q, target_d;
    logic [CUM_W-1:0]   total_q, total_d;
    logic               found_q, found_d;
    logic               ofound_q, ofound_d;
    logic               valid_q, valid_d;
    logic [BIN_W-1:0]   bins_q [NUM_BINS];
    logic [BIN_W-1:0]   bin_rd;
    logic [CUM_W-1:0]   sum_upd;
    logic               accept;

    assign o_hist_ready = (state_q == S_IDLE);
    assign accept       = i_hist_valid && (state_q == S_IDLE);
    assign bin_rd       = bins_q[idx_q];
    assign sum_upd      = sum_q + CUM_W'(bin_rd);

    // Bin storage is data-only, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            bins_q <= i_histogram;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        thr_d    = thr_q;
        sum_d    = sum_q;
        target_d = target_q;
        total_d  = total_q;
        found_d  = found_q;
        ofound_d = ofound_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: begin
                if (i_hist_valid) begin
                    target_d = i_target;
                    idx_d    = '0;
                    sum_d    = '0;
                    found_d  = 1'b0;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                sum_d = sum_upd;
                idx_d = idx_q + IDX_W'(1);
                if (!found_q && (sum_upd >= target_q)) begin
                    thr_d   = idx_q;
                    found_d = 1'b1;
                end
                if (idx_q == IDX_W'(NUM_BINS - 1)) begin
                    total_d  = sum_upd;
                    ofound_d = found_d;
                    // Unreached target reports the last bin.
                    if (!found_d) begin
                        thr_d = IDX_W'(NUM_BINS - 1);
                    end
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            thr_q    <= '0;
            sum_q    <= '0;
            target_q <= '0;
            total_q  <= '0;
            found_q  <= 1'b0;
            ofound_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            thr_q    <= thr_d;
            sum_q    <= sum_d;
            target_q <= target_d;
            total_q  <= total_d;
            found_q  <= found_d;
            ofound_q <= ofound_d;
            valid_q  <= valid_d;
        end
    end

    assign o_threshold = thr_q;
    assign o_total     = total_q;
    assign o_found     = ofound_q;
    assign o_valid     = valid_q;

endmodule

// File: tb/tb_histogram_threshold.sv
// Self-checking bench for histogram_threshold: table of histogram patterns
// with expected results, plus stall and mid-scan reset sequences.
module tb_histogram_threshold;

    localparam int NB = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hv  = 1'b0;
    logic        rdy = 1'b0;
    logic [15:0] hist [NB];
    logic [23:0] tgt = '0;
    logic        hist_ready;
    logic [7:0]  thr;
    logic [23:0] total;
    logic        found;
    logic        valid;

    histogram_threshold dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_hist_valid (hv),
        .i_histogram  (hist),
        .o_hist_ready (hist_ready),
        .i_target     (tgt),
        .o_threshold  (thr),
        .o_total      (total),
        .o_found      (found),
        .o_valid      (valid),
        .i_ready      (rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fill;
        int sidx;
        int sval;
        int target;
        int thr;
        int total;
        bit found;
    } vec_t;

    typedef struct {
        int thr;
        int total;
        bit found;
    } exp_t;

    exp_t sb [$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic load(input int fill, input int sidx, input int sval);
        for (int i = 0; i < NB; i++) hist[i] = 16'(fill);
        if (sidx >= 0) hist[sidx] = 16'(sval);
    endtask

    function automatic exp_t model(input int t);
        exp_t e;
        int   s;
        s = 0;
        e.found = 1'b0;
        e.thr   = NB - 1;
        for (int i = 0; i < NB; i++) begin
            s += int'(hist[i]);
            if (!e.found && s >= t) begin
                e.found = 1'b1;
                e.thr   = i;
            end
        end
        e.total = s;
        return e;
    endfunction

    // Accepts the histogram/target currently driven, scrambles inputs during
    // the scan, and checks latency and result against the scoreboard.
    task automatic run_one(input string nm, input int e_thr, input int e_total, input bit e_found);
        exp_t e;
        int   cnt;
        bit   got;
        check({nm, " ready"}, hist_ready, 1);
        hv = 1'b1;
        e.thr = e_thr; e.total = e_total; e.found = e_found;
        sb.push_back(e);
        @(posedge clk); #1;
        hv = 1'b0;
        check({nm, " busy"}, hist_ready, 0);
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 400) begin
            for (int i = 0; i < NB; i++) hist[i] = 16'($urandom);
            tgt = 24'($urandom);
            @(posedge clk); #1;
            cnt++;
            got = valid;
        end
        check({nm, " latency"}, cnt, 256);
        e = sb.pop_front();
        if (got) begin
            check({nm, " threshold"}, thr, e.thr);
            check({nm, " total"}, total, e.total);
            check({nm, " found"}, found, e.found);
        end
    endtask

    task automatic handshake(input string nm);
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        check({nm, " idle after hs"}, {hist_ready, valid}, 2'b10);
    endtask

    vec_t vt [10];

    initial begin
        exp_t m;
        bit   seen;

        vt[0] = '{0,   -1, 0,    1,        255, 0,        1'b0};
        vt[1] = '{0,   10, 100,  50,       10,  100,      1'b1};
        vt[2] = '{1,   -1, 0,    128,      127, 256,      1'b1};
        vt[3] = '{1,   -1, 0,    0,        0,   256,      1'b1};
        vt[4] = '{65535, -1, 0,  16776960, 255, 16776960, 1'b1};
        vt[5] = '{1,   -1, 0,    256,      255, 256,      1'b1};
        vt[6] = '{1,   -1, 0,    257,      255, 256,      1'b0};
        vt[7] = '{0,   0,  5,    5,        0,   5,        1'b1};
        vt[8] = '{0,   255, 7,   3,        255, 7,        1'b1};
        vt[9] = '{2,   100, 1000, 1200,    100, 1510,     1'b1};

        load(0, -1, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {valid, found, thr, total}, '0);
        check("reset ready", hist_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 10; v++) begin
            load(vt[v].fill, vt[v].sidx, vt[v].sval);
            tgt = 24'(vt[v].target);
            run_one($sformatf("vec%0d", v), vt[v].thr, vt[v].total, vt[v].found);
            handshake($sformatf("vec%0d", v));
        end

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NB; i++) hist[i] = 16'($urandom_range(0, 300));
            tgt = 24'($urandom_range(0, 40000));
            m = model(int'(tgt));
            run_one($sformatf("rand%0d", r), m.thr, m.total, m.found);
            handshake($sformatf("rand%0d", r));
        end

        // Stall in S_DONE with the inputs moving underneath.
        load(0, 10, 100);
        tgt = 24'd50;
        run_one("stall", 10, 100, 1'b1);
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < NB; i++) hist[i] = 16'($urandom);
            tgt = 24'($urandom);
            @(posedge clk); #1;
            check("stall hold", {valid, found, thr, total}, {1'b1, 1'b1, 8'd10, 24'd100});
        end
        handshake("stall");
        load(1, -1, 0);
        tgt = 24'd128;
        run_one("back2back", 127, 256, 1'b1);
        handshake("back2back");

        // Reset 100 cycles into a scan.
        load(1, -1, 0);
        tgt = 24'd10;
        hv = 1'b1;
        @(posedge clk); #1;
        hv = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort ready", hist_ready, 1);
        check("abort outputs", {valid, found, thr, total}, '0);
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (valid) seen = 1'b1;
        end
        check("abort no result", seen, 0);
        load(0, 200, 40);
        tgt = 24'd40;
        run_one("after reset", 200, 40, 1'b1);
        handshake("after reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
